// File: rtl/alu_seq.sv
// Sequential ALU for the execute stage: registered result plus NZVC flags, with
// valid/ready handshakes on both sides and an iterative shift-add unsigned multiply.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t               state, state_nxt;
  logic                 accept, mul_start, mul_last;
  logic [SHW-1:0]       cnt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_sum;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH+1:0]     alu_res;

  // Single-cycle ops; returns {C, V, result}. Shifts carry a guard bit so the
  // last bit shifted out lands in a fixed position (and is 0 for a zero shift).
  function automatic logic [WIDTH+1:0] alu_eval(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0]    r;
    logic                c, v;
    logic [WIDTH:0]      ext;
    logic signed [WIDTH:0] sext;
    logic [SHW-1:0]      sh;
    sh   = b[SHW-1:0];
    r    = a;
    c    = 1'b0;
    v    = 1'b0;
    ext  = '0;
    sext = '0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ~ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin
        ext = {1'b0, a} << sh;
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
      end
      OP_SHR: begin
        ext = {a, 1'b0} >> sh;
        r   = ext[WIDTH:1];
        c   = ext[0];
      end
      OP_SRA: begin
        sext = $signed({a, 1'b0}) >>> sh;
        r    = sext[WIDTH:1];
        c    = sext[0];
      end
      default: r = a;
    endcase
    return {c, v, r};
  endfunction

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (sel == OP_MUL);
  assign mul_last  = (state == BUSY) && (cnt == CNT_LAST);
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);
  assign alu_res   = alu_eval(sel, A, B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = mul_start ? BUSY : HOLD;
      BUSY: if (mul_last) state_nxt = HOLD;
      HOLD: begin
        if (accept)         state_nxt = mul_start ? BUSY : HOLD;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == BUSY);
    out_valid = (state == HOLD);
    in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  end

  // Result/flag registers and the multiplier: multiplicand shifts left while the
  // multiplier shifts right, so each step only inspects mplier[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out    <= '0;
      N      <= 1'b0;
      Z      <= 1'b0;
      V      <= 1'b0;
      C      <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (mul_start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      cnt    <= '0;
    end else if (accept) begin
      Out <= alu_res[WIDTH-1:0];
      N   <= alu_res[WIDTH-1];
      Z   <= (alu_res[WIDTH-1:0] == '0);
      V   <= alu_res[WIDTH];
      C   <= alu_res[WIDTH+1];
    end else if (state == BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        Out <= acc_sum[WIDTH-1:0];
        N   <= acc_sum[WIDTH-1];
        Z   <= (acc_sum[WIDTH-1:0] == '0);
        V   <= |acc_sum[2*WIDTH-1:WIDTH];
        C   <= |acc_sum[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed corner cases plus
// randomized traffic with backpressure, scored against an arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic        N, Z, V, C;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int retired = 0;
  logic [19:0] exp_q[$];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .N(N), .Z(Z), .V(V), .C(C), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {N,Z,V,C,result} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int unsigned ua, ub, r, sh;
    int          sa, sb, s;
    logic        c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    sh = ub % 16; c = 1'b0; v = 1'b0; r = ua;
    case (op)
      4'd0: begin r = (ua + ub) & 16'hFFFF; c = ((ua + ub) >> 16) != 0;
                  s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'd1: begin r = (ua - ub) & 16'hFFFF; c = (ua >= ub);
                  s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: begin r = (ua << sh) & 16'hFFFF; c = (sh != 0) && (((ua >> (16 - sh)) & 1) != 0); end
      4'd6: begin r = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0); end
      4'd7: begin r = (sa >>> sh) & 16'hFFFF; c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0); end
      4'd8: begin r = (ua * ub) & 16'hFFFF; c = ((ua * ub) >> 16) != 0; v = c; end
      default: r = ua;
    endcase
    return {r[15], (r[15:0] == 16'h0), v, c, r[15:0]};
  endfunction

  // Scoreboard: pop before push so a same-edge retire/accept keeps order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else begin
          check("result", {12'h0, N, Z, V, C, Out}, {12'h0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            retired++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(sel, A, B));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bit ok = 1'b0;
    sel = op; A = a; B = b; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] eo, input logic [3:0] ef);
    bit seen = 1'b0;
    issue(op, a, b);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check({tag, "_valid"}, {31'd0, seen}, 32'd1);
    check({tag, "_out"}, {16'h0, Out}, {16'h0, eo});
    check({tag, "_nzvc"}, {28'h0, N, Z, V, C}, {28'h0, ef});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] op;
    bit         took;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {16'h0, Out}, 32'h0);
    check("rst_vld_busy", {30'h0, out_valid, busy}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    issue(4'b1000, 16'd3, 16'd5);
    repeat (3) @(posedge clk);
    #1;
    check("mid_mul_busy", {31'h0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out", {16'h0, Out}, 32'h0);
    check("abort_nzvc", {28'h0, N, Z, V, C}, 32'h0);
    check("abort_vld_busy", {30'h0, out_valid, busy}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_stale", {31'h0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Flag and shift corner cases
    run_directed("add_ovf",   4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010);
    run_directed("add_carry", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101);
    run_directed("sub_borrow",4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000);
    run_directed("shl_c",     4'b0101, 16'h8001, 16'h0001, 16'h0002, 4'b0001);
    run_directed("sra_15",    4'b0111, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000);
    run_directed("shr_0",     4'b0110, 16'h0001, 16'h0000, 16'h0001, 4'b0000);
    run_directed("mul_7x9",   4'b1000, 16'd7,    16'd9,    16'd63,   4'b0000);
    run_directed("op_f",      4'b1111, 16'h1234, 16'hFFFF, 16'h1234, 4'b0000);

    // Multiply latency: busy for 16 cycles, result on the 17th
    issue(4'b1000, 16'h0100, 16'h0100);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("mul_busy", {29'h0, busy, in_ready, out_valid}, 32'b100);
    end
    @(negedge clk);
    check("mul_lat_vld", {30'h0, out_valid, busy}, 32'b10);
    check("mul_big_out", {16'h0, Out}, 32'h0);
    check("mul_big_nzvc", {28'h0, N, Z, V, C}, 32'b0111);
    @(posedge clk); #1;

    // Backpressure with a pending op, then same-edge retire and accept
    issue(4'b0000, 16'h0010, 16'h0020);
    out_ready = 1'b0;
    sel = 4'b0100; A = 16'h00FF; B = 16'h0F0F; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", {30'h0, in_ready, out_valid}, 32'b01);
      check("bp_stable", {16'h0, Out}, 32'h0030);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_vld", {31'h0, out_valid}, 32'd1);
    check("bp_next_out", {16'h0, Out}, 32'h0FF0);
    @(posedge clk); #1;

    // Eight back-to-back single-cycle ops
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd8) op = op + 4'd1;
      if (i == 7) op = 4'b1111;
      sel = op; A = 16'($urandom); B = 16'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check("stream_rdy", {31'h0, in_ready}, 32'd1);
      if (i > 0) check("stream_vld", {31'h0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_vld", {31'h0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Random traffic with random backpressure
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        sel = ($urandom_range(0, 4) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
        A = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        B = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 32'd0);
    check("retired_some", {31'h0, retired > 20}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential successor to the datapath's combinational ALU, with registered results and NZVC flags.
- Adds logical and arithmetic right shifts, variable shift amounts, and an iterative unsigned multiply.
- Sits in the execute stage and talks to the pipeline through a valid/ready handshake on both sides, so execute can stall on multi-cycle ops.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width, taken from B[SHW-1:0]; derived, do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block accepts an op on this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B / shift amount.
- sel  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- Out  out  WIDTH  registered result.
- N, Z, V, C  out  1 each  registered flags.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; Out=0, N=Z=V=C=0; out_valid=0; busy=0; multiply counter and accumulator cleared. Reset mid-multiply aborts it; no result is produced.
- Opcodes:
  - 0000 ADD: A+B. C = carry out; V = signed overflow.
  - 0001 SUB: A-B. C = 1 when A>=B unsigned (no borrow); V = signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR: C=V=0.
  - 0101 SHL, 0110 SHR (logical), 0111 SRA (arithmetic): shift A by B[SHW-1:0]. C = last bit shifted out (0 when amount is 0); V=0.
  - 1000 MUL: unsigned, low WIDTH bits to Out; C=V=1 when the upper WIDTH product bits are non-zero.
  - All other codes: Out=A, C=V=0.
- Flags are computed for every op: N = Out[WIDTH-1]; Z = (Out==0).
- Handshake:
  - Accept: in_valid && in_ready at a rising edge.
  - in_ready = (state!=BUSY) && (!out_valid || out_ready), i.e. combinational pass-through of out_ready.
  - Out/flags stay stable while out_valid=1 and out_ready=0.
  - Result retires at out_valid && out_ready.
- States:
  - IDLE: no result held. Non-MUL accept -> HOLD. MUL accept -> BUSY.
  - BUSY: busy=1, in_ready=0. One shift-add step per cycle, LSB of B first, with a counter 0..WIDTH-1. After step WIDTH-1 the result is written -> HOLD.
  - HOLD: out_valid=1.
    - out_ready && non-MUL accept -> HOLD with the new result (back-to-back).
    - out_ready && MUL accept -> BUSY.
    - out_ready with no accept -> IDLE.
    - !out_ready -> stay.
- Latency:
  - Non-MUL: out_valid rises the cycle after acceptance. With out_ready held high, throughput is 1 op/cycle.
  - MUL: out_valid rises WIDTH+1 cycles after acceptance (acceptance edge plus WIDTH step edges). Throughput is one MUL per WIDTH+1 cycles.
- Simultaneous retire and accept in the same cycle: the new result replaces the old one on that edge, and out_valid stays 1.
- Operands are captured at acceptance; changes on A/B/sel while BUSY have no effect.

Test Plan:
- Reset: hold rst_n=0 mid-MUL (WIDTH=16, A=3, B=5, 4 cycles in) -> Out=0, flags=0, out_valid=0, busy=0 immediately. After release, in_ready=1 and no stale result ever appears.
- Arithmetic flags, WIDTH=16, out_ready=1:
  - ADD 0x7FFF+0x0001 -> Out=0x8000, N=1, V=1, C=0, Z=0.
  - ADD 0xFFFF+0x0001 -> Out=0, Z=1, C=1, V=0.
  - SUB 0x0003-0x0005 -> Out=0xFFFE, C=0, N=1.
- Shifts:
  - SHL 0x8001 by 1 -> 0x0002, C=1.
  - SRA 0x8000 by 15 -> 0xFFFF, C=0.
  - SHR 0x0001 by 0 -> 0x0001, C=0.
- Multiply, WIDTH=16:
  - MUL 0x0100*0x0100 -> out_valid exactly 17 cycles after accept, Out=0x0000, Z=1, C=V=1, busy high for 16 cycles, in_ready low throughout.
  - MUL 7*9 -> Out=63, C=0.
- Backpressure: issue ADD, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and Out stable. On out_ready=1, retire and accept occur on the same edge and the next result appears the following cycle.
- Streaming: 8 consecutive non-MUL ops with in_valid=out_ready=1 -> 8 results on 8 consecutive cycles, in order, matching a reference model. Opcode 1111 returns A with C=V=0.
